// File: rtl/generador_simbolos_morse.sv
// Morse letter keyer: plays up to five dots/dashes from a latched pattern, then a 3-unit letter gap.
// Optional build macro MORSE_CANCELAR_EN adds a 'cancelar' input that aborts a letter in progress.
module generador_simbolos_morse #(
    parameter int DIV_UNIDAD = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic [4:0] patron,
    input  logic [2:0] longitud,
`ifdef MORSE_CANCELAR_EN
    input  logic       cancelar,
`endif
    output logic       salida,
    output logic       ocupado,
    output logic       fin
);

    typedef enum logic [1:0] {
        REPOSO      = 2'd0,
        MARCA       = 2'd1,
        ESPACIO     = 2'd2,
        PAUSA_LETRA = 2'd3
    } t_estado;

    localparam logic [4:0] DIV_FIN = 5'(DIV_UNIDAD - 1);

    t_estado    r_estado;
    t_estado    w_estado_sig;
    logic [4:0] r_div;
    logic [1:0] r_unidad;
    logic [2:0] r_indice;
    logic [4:0] r_patron;
    logic [2:0] r_longitud;
    logic       r_salida;
    logic       r_ocupado;
    logic       r_fin;

    logic       w_tick;
    logic       w_longitud_ok;
    logic       w_es_raya;
    logic       w_ultimo;
    logic [1:0] w_ultima_unidad;
    logic       w_arranque;
    logic       w_fin_sig;
    logic       w_indice_inc;

    function automatic logic f_bit_patron(input logic [4:0] p, input logic [2:0] i);
        case (i)
            3'd0:    f_bit_patron = p[0];
            3'd1:    f_bit_patron = p[1];
            3'd2:    f_bit_patron = p[2];
            3'd3:    f_bit_patron = p[3];
            3'd4:    f_bit_patron = p[4];
            default: f_bit_patron = 1'b0;
        endcase
    endfunction

    // Index of the last unit of the current mark: dash = 3 units, dot = 1 unit.
    function automatic logic [1:0] f_ultima_unidad(input logic es_raya);
        f_ultima_unidad = es_raya ? 2'd2 : 2'd0;
    endfunction

    assign w_tick          = (r_div == DIV_FIN);
    assign w_longitud_ok   = (longitud != 3'd0) && (longitud <= 3'd5);
    assign w_es_raya       = f_bit_patron(r_patron, r_indice);
    assign w_ultima_unidad = f_ultima_unidad(w_es_raya);
    assign w_ultimo        = (r_indice == (r_longitud - 3'd1));
    assign w_arranque      = (r_estado == REPOSO) && (w_estado_sig == MARCA);

    always_comb begin
        w_estado_sig = r_estado;
        w_fin_sig    = 1'b0;
        w_indice_inc = 1'b0;
        case (r_estado)
            REPOSO: begin
                if (inicio && w_longitud_ok) begin
                    w_estado_sig = MARCA;
                end
            end
            MARCA: begin
                if (w_tick && (r_unidad == w_ultima_unidad)) begin
                    w_estado_sig = w_ultimo ? PAUSA_LETRA : ESPACIO;
                end
            end
            ESPACIO: begin
                if (w_tick) begin
                    w_estado_sig = MARCA;
                    w_indice_inc = 1'b1;
                end
            end
            PAUSA_LETRA: begin
                if (w_tick && (r_unidad == 2'd2)) begin
                    w_estado_sig = REPOSO;
                    w_fin_sig    = 1'b1;
                end
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
`ifdef MORSE_CANCELAR_EN
        // Abort wins over everything else, and a cancelled letter never pulses fin.
        if (cancelar && (r_estado != REPOSO)) begin
            w_estado_sig = REPOSO;
            w_fin_sig    = 1'b0;
            w_indice_inc = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= REPOSO;
            r_div     <= 5'd0;
            r_unidad  <= 2'd0;
            r_indice  <= 3'd0;
            r_salida  <= 1'b0;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_salida  <= (w_estado_sig == MARCA);
            r_ocupado <= (w_estado_sig != REPOSO);
            r_fin     <= w_fin_sig;

            // Timing restarts on every state entry so each unit is exactly DIV_UNIDAD cycles.
            if ((w_estado_sig != r_estado) || (w_estado_sig == REPOSO)) begin
                r_div    <= 5'd0;
                r_unidad <= 2'd0;
            end else if (w_tick) begin
                r_div    <= 5'd0;
                r_unidad <= r_unidad + 2'd1;
            end else begin
                r_div    <= r_div + 5'd1;
            end

            if (w_arranque) begin
                r_indice <= 3'd0;
            end else if (w_indice_inc) begin
                r_indice <= r_indice + 3'd1;
            end
        end
    end

    // Letter data is only captured on acceptance and only read while busy.
    always_ff @(posedge clk) begin
        if (w_arranque) begin
            r_patron   <= patron;
            r_longitud <= longitud;
        end
    end

    assign salida  = r_salida;
    assign ocupado = r_ocupado;
    assign fin     = r_fin;

endmodule

// File: tb/tb_generador_simbolos_morse.sv
// Directed bench for generador_simbolos_morse with DIV_UNIDAD=4; cancel checks build with MORSE_CANCELAR_EN.
module tb_generador_simbolos_morse;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic [4:0] patron = 5'd0;
    logic [2:0] longitud = 3'd0;
`ifdef MORSE_CANCELAR_EN
    logic       cancelar = 1'b0;
`endif
    logic       salida;
    logic       ocupado;
    logic       fin;

    int n_assert = 0;
    int n_fail   = 0;

    generador_simbolos_morse #(.DIV_UNIDAD(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .patron   (patron),
        .longitud (longitud),
`ifdef MORSE_CANCELAR_EN
        .cancelar (cancelar),
`endif
        .salida   (salida),
        .ocupado  (ocupado),
        .fin      (fin)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nombre;
        logic [4:0] patron;
        logic [2:0] longitud;
        int         ciclos_fin;
        int         ciclos_altos;
        int         interf;
    } letra_t;

    letra_t tabla [7];

    task automatic chk(input string nombre, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nombre, act, req);
        end
    endtask

    // Reference keying: dot 1 unit, dash 3, 1-unit gap between symbols, low afterwards.
    function automatic logic modelo_salida(input logic [4:0] p, input int l, input int n);
        int t;
        int len;
        t = n / DIV;
        for (int i = 0; i < l; i++) begin
            len = p[i] ? 3 : 1;
            if (t < len) return 1'b1;
            t -= len;
            if (i < l - 1) begin
                if (t < 1) return 1'b0;
                t -= 1;
            end
        end
        return 1'b0;
    endfunction

    // n = samples after the accepting edge; n = ciclos_fin is the fin cycle.
    task automatic enviar(input letra_t v);
        int altos;
        int fin_ciclo;
        altos     = 0;
        fin_ciclo = -1;
        @(negedge clk);
        patron   = v.patron;
        longitud = v.longitud;
        inicio   = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= v.ciclos_fin + 1; n++) begin
            @(negedge clk);
            if (fin === 1'b1 && fin_ciclo < 0) fin_ciclo = n;
            if (n < v.ciclos_fin) begin
                if (salida === 1'b1) altos++;
                chk($sformatf("%s salida n=%0d", v.nombre, n), int'(salida),
                    int'(modelo_salida(v.patron, int'(v.longitud), n)));
                chk($sformatf("%s ocupado n=%0d", v.nombre, n), int'(ocupado), 1);
            end else if (n == v.ciclos_fin) begin
                chk($sformatf("%s fin-cycle ocupado", v.nombre), int'(ocupado), 0);
                chk($sformatf("%s fin-cycle salida", v.nombre), int'(salida), 0);
            end else begin
                chk($sformatf("%s fin one cycle", v.nombre), int'(fin), 0);
                chk($sformatf("%s idle ocupado", v.nombre), int'(ocupado), 0);
            end
            if (n == 0) begin
                inicio   = 1'b0;
                patron   = ~v.patron;
                longitud = 3'd7;
            end
            if (n == v.interf) begin
                inicio   = 1'b1;
                patron   = 5'b11111;
                longitud = 3'd5;
            end else if (n == v.interf + 1) begin
                inicio   = 1'b0;
            end
        end
        chk($sformatf("%s fin cycle", v.nombre), fin_ciclo, v.ciclos_fin);
        chk($sformatf("%s mark cycles", v.nombre), altos, v.ciclos_altos);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tabla[0] = '{"A",   5'b00010, 3'd2, 32, 16, -1};
        tabla[1] = '{"5",   5'b00000, 3'd5, 48, 20, -1};
        tabla[2] = '{"E",   5'b00000, 3'd1, 16,  4, -1};
        tabla[3] = '{"T",   5'b00001, 3'd1, 24, 12, -1};
        tabla[4] = '{"0",   5'b11111, 3'd5, 88, 60, -1};
        tabla[5] = '{"K",   5'b00101, 3'd3, 48, 28, -1};
        tabla[6] = '{"A+i", 5'b00010, 3'd2, 32, 16, 10};

        // Reset state, observed while reset is held and before any clock edge
        #2;
        chk("reset salida", int'(salida), 0);
        chk("reset ocupado", int'(ocupado), 0);
        chk("reset fin", int'(fin), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) enviar(tabla[i]);

        // Illegal lengths while idle never start a letter
        for (int l = 0; l < 8; l += 1) begin
            if (l >= 1 && l <= 5) continue;
            @(negedge clk);
            patron   = 5'b10101;
            longitud = 3'(l);
            inicio   = 1'b1;
            @(negedge clk);
            inicio   = 1'b0;
            chk($sformatf("len=%0d ocupado", l), int'(ocupado), 0);
            chk($sformatf("len=%0d salida", l), int'(salida), 0);
            @(negedge clk);
            chk($sformatf("len=%0d fin", l), int'(fin), 0);
        end

        // inicio held high: second letter starts in the fin cycle of the first
        @(negedge clk);
        patron   = 5'b00000;
        longitud = 3'd1;
        inicio   = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 34; n++) begin
            logic exp_sal;
            @(negedge clk);
            if (n < 16)                exp_sal = modelo_salida(5'b00000, 1, n);
            else if (n >= 17 && n < 33) exp_sal = modelo_salida(5'b00000, 1, n - 17);
            else                       exp_sal = 1'b0;
            chk($sformatf("back2back salida n=%0d", n), int'(salida), int'(exp_sal));
            chk($sformatf("back2back fin n=%0d", n), int'(fin), (n == 16 || n == 33) ? 1 : 0);
            chk($sformatf("back2back ocupado n=%0d", n), int'(ocupado),
                (n == 16 || n >= 33) ? 0 : 1);
            if (n == 17) inicio = 1'b0;
        end

        // Reset between clock edges in the middle of a dash
        @(negedge clk);
        patron   = 5'b00001;
        longitud = 3'd1;
        inicio   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        repeat (5) @(negedge clk);
        chk("dash before reset salida", int'(salida), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset salida", int'(salida), 0);
        chk("async reset ocupado", int'(ocupado), 0);
        chk("async reset fin", int'(fin), 0);
        @(negedge clk);
        reset = 1'b0;
        enviar(tabla[0]);

`ifdef MORSE_CANCELAR_EN
        // Cancel mid-mark together with inicio: back to idle, no fin, no restart
        @(negedge clk);
        patron   = 5'b00001;
        longitud = 3'd1;
        inicio   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        inicio   = 1'b1;
        cancelar = 1'b1;
        @(negedge clk);
        inicio   = 1'b0;
        cancelar = 1'b0;
        chk("cancel salida", int'(salida), 0);
        chk("cancel ocupado", int'(ocupado), 0);
        chk("cancel fin", int'(fin), 0);
        begin
            int fin_visto;
            int ocup_visto;
            fin_visto  = 0;
            ocup_visto = 0;
            repeat (30) begin
                @(negedge clk);
                if (fin === 1'b1) fin_visto++;
                if (ocupado === 1'b1) ocup_visto++;
            end
            chk("cancel no fin", fin_visto, 0);
            chk("cancel no restart", ocup_visto, 0);
        end
        // cancelar in idle does not block a start
        @(negedge clk);
        patron   = 5'b00000;
        longitud = 3'd1;
        inicio   = 1'b1;
        cancelar = 1'b1;
        @(negedge clk);
        inicio   = 1'b0;
        chk("cancel idle start ocupado", int'(ocupado), 1);
        @(negedge clk);
        cancelar = 1'b0;
        chk("cancel second ocupado", int'(ocupado), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
